// File: rtl/renkon_demux_input_pkg.sv
// Shared types and sizing for the renkon write-side demux.
// Core indices are 1-based; index 0 means "no core".
package renkon_demux_input_pkg;

    localparam int DWIDTH  = 16;
    localparam int CORE    = 8;
    localparam int CORELOG = 3;
    localparam int AWIDTH  = 10;
    localparam int CW      = CORELOG + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic cfg_ok(
        input logic [CW-1:0]     base,
        input logic [CW-1:0]     n,
        input logic [AWIDTH-1:0] wlen
    );
        return (base != '0) && (n != '0) && (wlen != '0)
            && (int'(base) + int'(n) <= CORE + 1);
    endfunction

    // One-hot strobe for core (base + off), bit k = core k+1.
    function automatic logic [CORE-1:0] core_sel(
        input logic [CW-1:0] base,
        input logic [CW-1:0] off
    );
        logic [CW-1:0] idx;
        idx = base + off - CW'(1);
        return CORE'(1) << idx;
    endfunction

endpackage

// File: rtl/renkon_demux_input_ctr.sv
// Word-address / core-offset counter pair for the input demux.
// last flags the final word of the final core.
module renkon_demux_input_ctr
    import renkon_demux_input_pkg::*;
(
    input  logic              clk,
    input  logic              xrst,
    input  logic              clear,
    input  logic              step,
    input  logic [AWIDTH-1:0] wlen,
    input  logic [CW-1:0]     n_cores,
    output logic [AWIDTH-1:0] addr,
    output logic [CW-1:0]     core_off,
    output logic              last
);

    logic wrap;

    assign wrap = (addr == wlen - AWIDTH'(1));
    assign last = wrap && (core_off == n_cores - CW'(1));

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            addr     <= '0;
            core_off <= '0;
        end else if (clear) begin
            addr     <= '0;
            core_off <= '0;
        end else if (step) begin
            if (wrap) begin
                addr     <= '0;
                core_off <= core_off + CW'(1);
            end else begin
                addr <= addr + AWIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/renkon_demux_input.sv
// Scatters a valid/ready word stream into per-core local buffers,
// wlen words per core, starting at core_base, for n_cores cores.
module renkon_demux_input
    import renkon_demux_input_pkg::*;
(
    input  logic                     clk,
    input  logic                     xrst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [CW-1:0]            core_base,
    input  logic [CW-1:0]            n_cores,
    input  logic [AWIDTH-1:0]        wlen,
    input  logic                     in_valid,
    input  logic signed [DWIDTH-1:0] in_data,
    output logic                     in_ready,
    output logic [CORE-1:0]          write_en,
    output logic [AWIDTH-1:0]        write_addr,
    output logic signed [DWIDTH-1:0] write_data,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    state_t            state;
    logic [CW-1:0]     base_q;
    logic [CW-1:0]     n_q;
    logic [AWIDTH-1:0] wlen_q;
    logic [AWIDTH-1:0] addr;
    logic [CW-1:0]     core_off;
    logic              last;
    logic              ok;
    logic              accept;
    logic              clear;

    assign ok       = cfg_ok(core_base, n_cores, wlen);
    assign in_ready = (state == S_RUN);
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    assign accept   = in_valid && (state == S_RUN) && !abort;
    assign clear    = start && (state == S_IDLE) && !abort;

    renkon_demux_input_ctr u_ctr (
        .clk      (clk),
        .xrst     (xrst),
        .clear    (clear),
        .step     (accept),
        .wlen     (wlen_q),
        .n_cores  (n_q),
        .addr     (addr),
        .core_off (core_off),
        .last     (last)
    );

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state      <= S_IDLE;
            base_q     <= '0;
            n_q        <= '0;
            wlen_q     <= '0;
            write_en   <= '0;
            write_addr <= '0;
            write_data <= '0;
            err        <= 1'b0;
        end else begin
            write_en <= '0;
            if (abort) begin
                state <= S_IDLE;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start) begin
                            base_q <= core_base;
                            n_q    <= n_cores;
                            wlen_q <= wlen;
                            err    <= !ok;
                            state  <= ok ? S_RUN : S_DONE;
                        end
                    end
                    S_RUN: begin
                        if (in_valid) begin
                            write_en   <= core_sel(base_q, core_off);
                            write_addr <= addr;
                            write_data <= in_data;
                            if (last) state <= S_DONE;
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_renkon_demux_input.sv
// Randomized bench for renkon_demux_input against a word-index
// reference model (core = base + k / wlen, addr = k % wlen).
module tb_renkon_demux_input;

    logic        clk = 1'b0;
    logic        xrst;
    logic        start;
    logic        abort;
    logic [3:0]  core_base;
    logic [3:0]  n_cores;
    logic [9:0]  wlen;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic [7:0]  write_en;
    logic [9:0]  write_addr;
    logic [15:0] write_data;
    logic        busy;
    logic        done;
    logic        err;

    int n_vec = 0;
    int n_bad = 0;

    // reference model state: 0 idle, 1 run, 2 done
    int          m_st;
    int          m_k;
    int          m_total;
    int          m_base;
    int          m_wlen;
    logic        m_err;
    logic [7:0]  e_en;
    logic [9:0]  e_addr;
    logic [15:0] e_data;

    int edges;
    int n_wr;
    int n_done;
    int done_at;

    always #5 clk = ~clk;

    renkon_demux_input dut (
        .clk        (clk),
        .xrst       (xrst),
        .start      (start),
        .abort      (abort),
        .core_base  (core_base),
        .n_cores    (n_cores),
        .wlen       (wlen),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .write_en   (write_en),
        .write_addr (write_addr),
        .write_data (write_data),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_st   = 0;
        m_k    = 0;
        m_err  = 1'b0;
        e_en   = '0;
        e_addr = '0;
        e_data = '0;
    endtask

    task automatic model_edge();
        int core;
        bit ok;
        if (!xrst) begin
            m_reset();
            return;
        end
        e_en = '0;
        if (abort) begin
            m_st = 0;
        end else begin
            case (m_st)
                0: if (start) begin
                    ok = core_base >= 1 && n_cores >= 1 && wlen >= 1
                      && int'(core_base) + int'(n_cores) - 1 <= 8;
                    m_base  = int'(core_base);
                    m_wlen  = int'(wlen);
                    m_total = int'(n_cores) * int'(wlen);
                    m_k     = 0;
                    m_err   = !ok;
                    m_st    = ok ? 1 : 2;
                end
                1: if (in_valid) begin
                    core   = m_base + m_k / m_wlen;
                    e_en   = 8'(1 << (core - 1));
                    e_addr = 10'(m_k % m_wlen);
                    e_data = in_data;
                    m_k++;
                    if (m_k == m_total) m_st = 2;
                end
                default: m_st = 0;
            endcase
        end
    endtask

    task automatic check_all();
        chk("in_ready", 32'(in_ready), 32'(m_st == 1));
        chk("busy", 32'(busy), 32'(m_st != 0));
        chk("done", 32'(done), 32'(m_st == 2));
        chk("err", 32'(err), 32'(m_err));
        chk("write_en", 32'(write_en), 32'(e_en));
        chk("write_addr", 32'(write_addr), 32'(e_addr));
        chk("write_data", 32'(write_data), 32'(e_data));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
        edges++;
        if (write_en != '0) n_wr++;
        if (done) begin
            n_done++;
            done_at = edges;
        end
    endtask

    // mode 0: in_valid always 1, 1: toggles 1010.., 2: random + stray starts
    task automatic run_xfer(input int base, input int n, input int wl,
                            input int mode, input int abort_at,
                            input int dstart);
        bit   tog;
        int   dseq;
        edges   = 0;
        n_wr    = 0;
        n_done  = 0;
        done_at = 0;
        dseq    = dstart;
        tog     = 1'b1;
        core_base = 4'(base);
        n_cores   = 4'(n);
        wlen      = 10'(wl);
        in_valid  = 1'b0;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        core_base = 4'($urandom);
        n_cores   = 4'($urandom);
        wlen      = 10'($urandom);
        for (int i = 0; i < 5000 && m_st != 0; i++) begin
            case (mode)
                0:       in_valid = 1'b1;
                1: begin in_valid = tog; tog = !tog; end
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            if (abort_at >= 0 && m_st == 1 && m_k == abort_at) begin
                abort    = 1'b1;
                in_valid = 1'b0;
            end
            if (mode == 2) start = ($urandom_range(0, 7) == 0);
            in_data = in_valid ? 16'(dseq) : 16'($urandom);
            if (in_valid && m_st == 1) dseq++;
            tick();
            abort = 1'b0;
            start = 1'b0;
        end
        if (m_st != 0) chk("timeout", 32'(1), 32'(0));
    endtask

    initial begin
        xrst      = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        core_base = '0;
        n_cores   = '0;
        wlen      = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        m_reset();
        @(negedge clk);
        check_all();
        xrst = 1'b1;
        tick();
        tick();

        run_xfer(1, 8, 4, 0, -1, 100);
        chk("full_writes", 32'(n_wr), 32'(32));
        chk("full_done_at", 32'(done_at), 32'(33));

        run_xfer(3, 2, 2, 0, -1, 10);
        chk("b3_writes", 32'(n_wr), 32'(4));
        chk("b3_done_at", 32'(done_at), 32'(5));

        run_xfer(3, 2, 2, 1, -1, 10);
        chk("tog_writes", 32'(n_wr), 32'(4));
        chk("tog_done_at", 32'(done_at), 32'(8));

        run_xfer(7, 3, 4, 0, -1, 0);
        chk("ovf_writes", 32'(n_wr), 32'(0));
        chk("ovf_done_at", 32'(done_at), 32'(1));
        chk("ovf_err", 32'(err), 32'(1));

        run_xfer(1, 1, 0, 0, -1, 0);
        chk("wl0_writes", 32'(n_wr), 32'(0));
        chk("wl0_err", 32'(err), 32'(1));

        run_xfer(1, 2, 4, 0, 5, 50);
        chk("abort_writes", 32'(n_wr), 32'(5));
        chk("abort_done", 32'(n_done), 32'(0));

        run_xfer(1, 2, 4, 0, -1, 60);
        chk("restart_writes", 32'(n_wr), 32'(8));
        chk("restart_err", 32'(err), 32'(0));

        // async reset in the middle of a transfer, with a stray start
        core_base = 4'd2;
        n_cores   = 4'd3;
        wlen      = 10'd5;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 16'($urandom);
            start   = (i == 1);
            core_base = 4'd1;
            tick();
        end
        start = 1'b0;
        #2 xrst = 1'b0;
        #1;
        m_reset();
        chk("rst_en", 32'(write_en), 32'(0));
        chk("rst_addr", 32'(write_addr), 32'(0));
        chk("rst_data", 32'(write_data), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_ready", 32'(in_ready), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        in_valid = 1'b0;
        tick();
        xrst = 1'b1;
        tick();

        for (int t = 0; t < 40; t++) begin
            int b;
            int n;
            int wl;
            int ab;
            b  = $urandom_range(0, 8);
            n  = $urandom_range(0, 8);
            wl = $urandom_range(0, 6);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n * wl) : -1;
            run_xfer(b, n, wl, 2, ab, $urandom_range(0, 65535));
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
